// File: rtl/prog_clk_divider.sv
// Programmable clock divider with glitch-free ratio reload at terminal count.
// Optional square-wave output enabled by defining DIV_TOGGLE_OUT_EN.
module prog_clk_divider #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tick,
    output logic             pending,
    output logic             div_out
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             halted;
    logic             tick_int;

    assign halted   = (ratio_q == '0);
    assign tick_int = en && !halted && (cnt_q == ratio_q - WIDTH'(1));

    always_comb begin
        cnt_d    = cnt_q;
        ratio_d  = ratio_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (halted) begin
            // A halted divider accepts a new ratio at once; there is no period to protect.
            cnt_d  = '0;
            pend_d = 1'b0;
            if (load) begin
                ratio_d = div_val;
            end
        end else begin
            if (en) begin
                cnt_d = tick_int ? '0 : cnt_q + WIDTH'(1);
            end
            if (tick_int) begin
                pend_d = 1'b0;
                if (load) begin
                    ratio_d = div_val;
                end else if (pend_q) begin
                    ratio_d = shadow_q;
                end
            end else if (load) begin
                shadow_d = div_val;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ratio_q  <= WIDTH'(RESET_DIV);
            shadow_q <= WIDTH'(RESET_DIV);
            pend_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end

`ifdef DIV_TOGGLE_OUT_EN
    logic tog_q, tog_d;

    always_comb begin
        tog_d = tog_q;
        if (tick_int) begin
            tog_d = ~tog_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign div_out = tog_q;
`else
    assign div_out = 1'b0;
`endif

    assign count_out = cnt_q;
    assign tick      = tick_int;
    assign pending   = pend_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Scoreboard bench for prog_clk_divider: a behavioural model predicts each cycle's outputs.
module tb_prog_clk_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] div_val = '0;
    logic [W-1:0] count_out;
    logic         tick;
    logic         pending;
    logic         div_out;

    prog_clk_divider #(.WIDTH(W), .RESET_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .div_val(div_val),
        .count_out(count_out), .tick(tick), .pending(pending), .div_out(div_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit tck;
        bit pnd;
        bit dout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state: position within the period, active/shadow ratio.
    int m_cnt = 0, m_r = 4, m_s = 4;
    bit m_pend = 0, m_tog = 0;
    bit armed = 0;

    task automatic step(input bit e, input bit l, input int d, input bit rn);
        exp_t x;
        bit   t;
        @(posedge clk);
        #1;
        en = e; load = l; div_val = W'(d); rst_n = rn;
        t = e && (m_r != 0) && (m_cnt == m_r - 1);
        x.cnt = m_cnt; x.tck = t; x.pnd = m_pend;
`ifdef DIV_TOGGLE_OUT_EN
        x.dout = m_tog;
`else
        x.dout = 1'b0;
`endif
        if (armed) exp_q.push_back(x);
        if (!rn) begin
            m_cnt = 0; m_r = 4; m_s = 4; m_pend = 0; m_tog = 0;
        end else if (m_r == 0) begin
            m_cnt = 0;
            if (l) m_r = d;
        end else begin
            if (e) m_cnt = (m_cnt + 1) % m_r;
            if (t) begin
                m_cnt = 0;
                m_tog = ~m_tog;
                if (l) m_r = d;
                else if (m_pend) m_r = m_s;
                m_pend = 0;
            end else if (l) begin
                m_s = d;
                m_pend = 1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1);
    endtask

    // Advance until the next driven cycle is a tick cycle, then load in it.
    task automatic load_at_tick(input int d);
        int guard = 0;
        while (!(m_r != 0 && m_cnt == m_r - 1) && guard < 300) begin
            step(1, 0, 0, 1);
            guard++;
        end
        checks++;
        if (guard >= 300) begin
            failures++;
            $display("FAIL load_at_tick: no tick within bound, ratio=%0d required a tick", m_r);
        end
        step(1, 1, d, 1);
    endtask

    task automatic load_at_count(input int c, input int d);
        int guard = 0;
        while (m_cnt != c && guard < 300) begin
            step(1, 0, 0, 1);
            guard++;
        end
        checks++;
        if (guard >= 300) begin
            failures++;
            $display("FAIL load_at_count: count %0d never reached", c);
        end
        step(1, 1, d, 1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks += 4;
            if (count_out !== W'(x.cnt)) begin
                failures++;
                $display("FAIL count_out: got %0d expected %0d at %0t", count_out, x.cnt, $time);
            end
            if (tick !== x.tck) begin
                failures++;
                $display("FAIL tick: got %b expected %b at %0t", tick, x.tck, $time);
            end
            if (pending !== x.pnd) begin
                failures++;
                $display("FAIL pending: got %b expected %b at %0t", pending, x.pnd, $time);
            end
            if (div_out !== x.dout) begin
                failures++;
                $display("FAIL div_out: got %b expected %b at %0t", div_out, x.dout, $time);
            end
        end
    end

    initial begin
        step(0, 0, 0, 0);
        armed = 1;
        step(0, 0, 0, 0);
        // Default ratio after reset
        run(13);
        // Deferred load at count 1
        load_at_count(1, 6);
        run(14);
        // Simultaneous load and tick: back to 4, then 3
        load_at_tick(4);
        load_at_tick(3);
        run(10);
        // Halt, then restart with 5
        step(1, 1, 0, 1);
        run(8);
        step(1, 1, 5, 1);
        run(12);
        // Enable gating mid-period
        load_at_count(2, 5);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        run(8);
        // Pass-through ratio 1
        step(1, 1, 1, 1);
        run(8);
        // Square wave with ratio 3
        load_at_tick(3);
        run(14);
        // Reset mid-period discards pending ratio
        load_at_count(1, 7);
        step(1, 0, 0, 0);
        run(10);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit e, l, rn;
            e  = ($urandom_range(0, 9) != 0);
            l  = ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 99) != 0);
            step(e, l, $urandom_range(0, 9), rn);
        end
        step(0, 0, 0, 1);
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
